// File: rtl/imem_fetch_if_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : imem_fetch_if_pkg                                       |
// | Description: Shared constants for the fetch-stage imem interface.    |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
package imem_fetch_if_pkg;

   localparam int unsigned C_XLEN      = 32;
   localparam logic [31:0] C_NOP_INSTR = 32'h0000_0013;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_WAIT = 1'b1;

   function automatic logic is_word_aligned(input logic [1:0] lsb);
      return (lsb == 2'b00);
   endfunction

endpackage
`default_nettype wire

// File: rtl/imem_fetch_if_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : imem_fetch_if_if                                        |
// | Description: req/ack instruction memory bus with master/slave views. |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
interface imem_fetch_if_if #(
   parameter int XLEN = 32
);
   logic            req;
   logic [XLEN-1:0] addr;
   logic            ack;
   logic [XLEN-1:0] rdata;

   modport master (output req, addr, input ack, rdata);
   modport slave  (input req, addr, output ack, rdata);
endinterface
`default_nettype wire

// File: rtl/imem_fetch_if_fetch_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : fetch_buf                                               |
// | Description: Single-entry tagged instruction buffer.                 |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module fetch_buf #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            wr,
   input  logic [XLEN-1:0] wr_addr,
   input  logic [XLEN-1:0] wr_data,
   input  logic [XLEN-1:0] lookup_addr,
   output logic            hit,
   output logic [XLEN-1:0] rd_data
);
   logic            valid_q;
   logic [XLEN-1:0] addr_q;
   logic [XLEN-1:0] data_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else if (wr) begin
         valid_q <= 1'b1;
         addr_q  <= wr_addr;
         data_q  <= wr_data;
      end
   end

   assign hit     = valid_q && (addr_q == lookup_addr);
   assign rd_data = data_q;
endmodule
`default_nettype wire

// File: rtl/imem_fetch_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : imem_fetch_if                                           |
// | Description: Fetch-stage imem front end: FSM, buffer and bypass mux. |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module imem_fetch_if
   import imem_fetch_if_pkg::*;
#(
   parameter int              XLEN      = C_XLEN,
   parameter logic [XLEN-1:0] NOP_INSTR = C_NOP_INSTR
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [XLEN-1:0]   PCF,
   input  logic              StallF,
   output logic [XLEN-1:0]   InstrF,
   output logic              FetchBusyF,
   output logic              FetchMisalignF,
   imem_fetch_if_if.master   imem
);
   logic [0:0]      state_q, state_d;
   logic [XLEN-1:0] out_addr_q, out_addr_d;

   logic            w_aligned;
   logic            w_buf_hit;
   logic [XLEN-1:0] w_buf_data;
   logic            w_idle_req;
   logic            w_wait_req;
   logic [XLEN-1:0] w_req_addr;
   logic            w_fill;
   logic            w_byp_hit;
   logic            w_hit;

   // A hit already keeps InstrF stable, so the stall needs no extra handling.
   logic w_unused_stall;
   assign w_unused_stall = StallF;

   assign w_aligned  = is_word_aligned(PCF[1:0]);
   assign w_idle_req = !reset && (state_q == S_IDLE) && !w_buf_hit && w_aligned;
   assign w_wait_req = !reset && (state_q == S_WAIT);
   assign w_req_addr = (state_q == S_WAIT) ? out_addr_q : PCF;
   assign w_fill     = (w_idle_req || w_wait_req) && imem.ack;
   assign w_byp_hit  = w_fill && (w_req_addr == PCF);
   assign w_hit      = !reset && w_aligned && (w_buf_hit || w_byp_hit);

   fetch_buf #(
      .XLEN (XLEN)
   ) u_fetch_buf (
      .clk         (clk),
      .reset       (reset),
      .wr          (w_fill),
      .wr_addr     (w_req_addr),
      .wr_data     (imem.rdata),
      .lookup_addr (PCF),
      .hit         (w_buf_hit),
      .rd_data     (w_buf_data)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         out_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         out_addr_q <= out_addr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      out_addr_d = out_addr_q;
      case (state_q)
         S_IDLE: begin
            if (w_idle_req && !imem.ack) begin
               state_d    = S_WAIT;
               out_addr_d = PCF;
            end
         end
         S_WAIT: begin
            if (imem.ack) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      imem.req       = w_idle_req || w_wait_req;
      imem.addr      = w_idle_req ? PCF : out_addr_q;
      FetchMisalignF = !w_aligned;
      FetchBusyF     = !w_hit;
      InstrF         = NOP_INSTR;
      if (w_hit) begin
         InstrF = w_buf_hit ? w_buf_data : imem.rdata;
      end
   end
endmodule
`default_nettype wire
